// File: rtl/fht_frame_ctrl_if.sv
// rtl/fht_frame_ctrl_if.sv - signal bundle between fht_frame_ctrl and its environment
//
// Purpose: groups the ADC sample stream, the fht_top RAM/start/ready port and the
// result stream into one interface.
// Modports:
//   master - the frame sequencer (drives oADC_READY, oFHT_*, oOUT_*, oBUSY)
//   slave  - the surrounding system (ADC source, fht_top, result sink)
// Signals:
//   iADC_VALID/iADC_DATA/oADC_READY        sample stream in
//   oFHT_WE/oFHT_DATA/oFHT_ADDR_WR         bank write port
//   oFHT_START/iFHT_RDY                    transform start pulse / done level
//   oFHT_ADDR_RD/iFHT_DATA_0..3            bank read port
//   oOUT_VALID/oOUT_DATA/oOUT_LAST/iOUT_READY  result stream out
//   oBUSY                                  sequencer is not loading
interface fht_frame_ctrl_if #(
  parameter int ADC_WIDTH = 16,
  parameter int D_BIT     = 22,
  parameter int A_BIT     = 8
);
  logic                 iADC_VALID;
  logic [ADC_WIDTH-1:0] iADC_DATA;
  logic                 oADC_READY;
  logic [3:0]           oFHT_WE;
  logic [D_BIT-1:0]     oFHT_DATA;
  logic [A_BIT-1:0]     oFHT_ADDR_WR;
  logic                 oFHT_START;
  logic                 iFHT_RDY;
  logic [A_BIT-1:0]     oFHT_ADDR_RD;
  logic [D_BIT-1:0]     iFHT_DATA_0;
  logic [D_BIT-1:0]     iFHT_DATA_1;
  logic [D_BIT-1:0]     iFHT_DATA_2;
  logic [D_BIT-1:0]     iFHT_DATA_3;
  logic                 oOUT_VALID;
  logic [D_BIT-1:0]     oOUT_DATA;
  logic                 oOUT_LAST;
  logic                 iOUT_READY;
  logic                 oBUSY;

  modport master (
    input  iADC_VALID, iADC_DATA, iFHT_RDY,
           iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3, iOUT_READY,
    output oADC_READY, oFHT_WE, oFHT_DATA, oFHT_ADDR_WR, oFHT_START,
           oFHT_ADDR_RD, oOUT_VALID, oOUT_DATA, oOUT_LAST, oBUSY
  );

  modport slave (
    output iADC_VALID, iADC_DATA, iFHT_RDY,
           iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3, iOUT_READY,
    input  oADC_READY, oFHT_WE, oFHT_DATA, oFHT_ADDR_WR, oFHT_START,
           oFHT_ADDR_RD, oOUT_VALID, oOUT_DATA, oOUT_LAST, oBUSY
  );
endinterface

// File: rtl/fht_frame_ctrl.sv
// rtl/fht_frame_ctrl.sv - frame sequencer in front of fht_top
//
// Purpose: loads one frame of N = 4*2^A_BIT ADC samples into the four FHT banks,
// pulses start, waits for the rising edge of the done level, then reads the
// result back row by row in bit-reversed row order and streams it out.
// Ports:
//   iCLK    clock, rising edge
//   iRESET  asynchronous active-high reset
//   bus     fht_frame_ctrl_if.master (sample stream, FHT RAM port, result stream)
module fht_frame_ctrl #(
  parameter int ADC_WIDTH = 16,
  parameter int D_BIT     = 22,
  parameter int A_BIT     = 8,
  parameter int RD_LAT    = 2
) (
  input logic               iCLK,
  input logic               iRESET,
  fht_frame_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_RADDR,
    S_RWAIT,
    S_OUT
  } state_t;

  localparam logic [A_BIT+1:0] K_LAST   = '1;
  localparam logic [A_BIT+1:0] K_ONE    = 1;
  localparam logic [A_BIT-1:0] ROW_LAST = '1;
  localparam logic [A_BIT-1:0] ROW_ONE  = 1;
  localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);

  state_t           state;
  logic [A_BIT+1:0] k;        // sample index within the frame
  logic [A_BIT-1:0] r;        // readout row, natural order
  logic [1:0]       b;        // bank index within the held row
  logic [1:0]       lat_cnt;
  logic             rdy_q;    // previous-cycle copy of iFHT_RDY
  logic [D_BIT-1:0] hold [4];

  function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] x);
    logic [A_BIT-1:0] y;
    for (int i = 0; i < A_BIT; i++) begin
      y[i] = x[A_BIT-1-i];
    end
    return y;
  endfunction

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state            <= S_LOAD;
      k                <= '0;
      r                <= '0;
      b                <= '0;
      lat_cnt          <= '0;
      rdy_q            <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
      end
      bus.oADC_READY   <= 1'b0;
      bus.oFHT_WE      <= '0;
      bus.oFHT_DATA    <= '0;
      bus.oFHT_ADDR_WR <= '0;
      bus.oFHT_START   <= 1'b0;
      bus.oFHT_ADDR_RD <= '0;
      bus.oOUT_VALID   <= 1'b0;
      bus.oOUT_DATA    <= '0;
      bus.oOUT_LAST    <= 1'b0;
      bus.oBUSY        <= 1'b0;
    end else begin
      // Edge detector input runs every cycle so a level left high from a
      // previous frame never looks like a fresh completion.
      rdy_q          <= bus.iFHT_RDY;
      bus.oFHT_WE    <= '0;
      bus.oFHT_START <= 1'b0;

      case (state)
        S_LOAD: begin
          bus.oADC_READY <= 1'b1;
          bus.oBUSY      <= 1'b0;
          if (bus.iADC_VALID && bus.oADC_READY) begin
            // Row-major: consecutive samples rotate through the four banks.
            bus.oFHT_WE      <= 4'b0001 << k[1:0];
            bus.oFHT_DATA    <= {bus.iADC_DATA, {(D_BIT-ADC_WIDTH){1'b0}}};
            bus.oFHT_ADDR_WR <= k[A_BIT+1:2];
            k                <= k + K_ONE;
            if (k == K_LAST) begin
              bus.oADC_READY <= 1'b0;
              bus.oBUSY      <= 1'b1;
              state          <= S_START;
            end
          end
        end

        S_START: begin
          bus.oFHT_START <= 1'b1;
          state          <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.iFHT_RDY && !rdy_q) begin
            r                <= '0;
            bus.oFHT_ADDR_RD <= '0;
            state            <= S_RADDR;
          end
        end

        S_RADDR: begin
          lat_cnt <= '0;
          state   <= S_RWAIT;
        end

        S_RWAIT: begin
          if (lat_cnt == LAT_LAST) begin
            hold[0]        <= bus.iFHT_DATA_0;
            hold[1]        <= bus.iFHT_DATA_1;
            hold[2]        <= bus.iFHT_DATA_2;
            hold[3]        <= bus.iFHT_DATA_3;
            bus.oOUT_DATA  <= bus.iFHT_DATA_0;
            bus.oOUT_VALID <= 1'b1;
            bus.oOUT_LAST  <= 1'b0;
            b              <= '0;
            state          <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        S_OUT: begin
          if (bus.iOUT_READY) begin
            if (b == 2'd3) begin
              bus.oOUT_VALID <= 1'b0;
              bus.oOUT_LAST  <= 1'b0;
              if (r == ROW_LAST) begin
                bus.oADC_READY <= 1'b1;
                bus.oBUSY      <= 1'b0;
                state          <= S_LOAD;
              end else begin
                r                <= r + ROW_ONE;
                bus.oFHT_ADDR_RD <= bitrev(r + ROW_ONE);
                state            <= S_RADDR;
              end
            end else begin
              b             <= b + 2'd1;
              bus.oOUT_DATA <= hold[b + 2'd1];
              bus.oOUT_LAST <= (r == ROW_LAST) && (b == 2'd2);
            end
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// tb/tb_fht_frame_ctrl.sv - directed self-checking bench for fht_frame_ctrl
module tb_fht_frame_ctrl;
  localparam int ADC_WIDTH = 16;
  localparam int D_BIT     = 22;
  localparam int A_BIT     = 2;
  localparam int RD_LAT    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad = 0;
  logic [15:0] cur_seed;

  fht_frame_ctrl_if #(.ADC_WIDTH(ADC_WIDTH), .D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

  fht_frame_ctrl #(
    .ADC_WIDTH(ADC_WIDTH),
    .D_BIT    (D_BIT),
    .A_BIT    (A_BIT),
    .RD_LAT   (RD_LAT)
  ) dut (
    .iCLK  (clk),
    .iRESET(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FHT RAM: four banks, two-cycle registered read, no transform.
  logic [D_BIT-1:0] mem [4][4];
  logic [D_BIT-1:0] p1 [4];
  logic [D_BIT-1:0] p2 [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.oFHT_WE[i]) mem[i][bus.oFHT_ADDR_WR] <= bus.oFHT_DATA;
      p1[i] <= mem[i][bus.oFHT_ADDR_RD];
      p2[i] <= p1[i];
    end
  end

  assign bus.iFHT_DATA_0 = p2[0];
  assign bus.iFHT_DATA_1 = p2[1];
  assign bus.iFHT_DATA_2 = p2[2];
  assign bus.iFHT_DATA_3 = p2[3];

  function automatic logic [56:0] outs();
    return {bus.oADC_READY, bus.oFHT_WE, bus.oFHT_DATA, bus.oFHT_ADDR_WR, bus.oFHT_START,
            bus.oFHT_ADDR_RD, bus.oOUT_VALID, bus.oOUT_DATA, bus.oOUT_LAST, bus.oBUSY};
  endfunction

  function automatic logic [D_BIT-1:0] word_of(input int k);
    logic [15:0] s;
    s = cur_seed + 16'(k);
    return {s, {(D_BIT-ADC_WIDTH){1'b0}}};
  endfunction

  function automatic int rowrev(input int x);
    return ((x & 1) << 1) | ((x >> 1) & 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input bit gap, input int n);
    int k, cyc, gapbad;
    bit acc;
    logic [3:0] ew;
    k = 0; cyc = 0; gapbad = 0;
    while (k < n && cyc < 200) begin
      bus.iADC_VALID = !(gap && (cyc % 2 == 1));
      bus.iADC_DATA  = cur_seed + 16'(k);
      acc = bus.iADC_VALID && bus.oADC_READY;
      tick();
      cyc++;
      if (acc) begin
        ew = 4'b0001 << k[1:0];
        chk($sformatf("load_wr%0d", k), {bus.oFHT_WE, bus.oFHT_ADDR_WR, bus.oFHT_DATA},
            {ew, 2'(k / 4), word_of(k)});
        k++;
      end else if (bus.oFHT_WE !== 4'b0) begin
        gapbad++;
      end
    end
    bus.iADC_VALID = 1'b0;
    chk("load_count", k, n);
    if (gap) chk("load_gap_we", gapbad, 0);
  endtask

  task automatic after_load();
    chk("ready_drop", bus.oADC_READY, 0);
    tick();
    chk("start_pulse", {bus.oFHT_START, bus.oFHT_WE}, {1'b1, 4'b0000});
    tick();
    chk("start_end", {bus.oFHT_START, bus.oBUSY}, 2'b01);
  endtask

  task automatic wait_phase(input bit adc_hi);
    int badc;
    badc = 0;
    bus.iADC_VALID = adc_hi;
    repeat (3) begin
      tick();
      if (bus.oOUT_VALID !== 1'b0 || bus.oFHT_WE !== 4'b0 || bus.oFHT_START !== 1'b0) badc++;
    end
    bus.iFHT_RDY = 1'b0;
    repeat (20) begin
      tick();
      if (bus.oOUT_VALID !== 1'b0 || bus.oFHT_WE !== 4'b0 || bus.oFHT_START !== 1'b0) badc++;
    end
    chk("wait_idle", badc, 0);
    bus.iFHT_RDY = 1'b1;
    tick();
    chk("rise_addr", {bus.oFHT_ADDR_RD, bus.oOUT_VALID, bus.oBUSY}, {2'b00, 1'b0, 1'b1});
  endtask

  task automatic drain(input bit rnd, input int nw);
    logic pv, pl, hs;
    logic [D_BIT-1:0] pd;
    logic [1:0] pa;
    logic [7:0] alog;
    int naddr, got, cyc, last_edge, stallbad, addrbad, webad, kk;
    alog = {6'b0, bus.oFHT_ADDR_RD};
    naddr = 1; got = 0; cyc = 0; last_edge = 0; stallbad = 0; addrbad = 0; webad = 0;
    while (got < nw && cyc < 1000) begin
      bus.iOUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = bus.oOUT_VALID;
      pd = bus.oOUT_DATA;
      pl = bus.oOUT_LAST;
      pa = bus.oFHT_ADDR_RD;
      hs = pv && bus.iOUT_READY;
      if (hs) begin
        kk = rowrev(got / 4) * 4 + got % 4;
        chk($sformatf("out%0d", got), {pl, pd}, {1'(got == 15), word_of(kk)});
        got++;
        last_edge = cyc + 1;
      end
      tick();
      cyc++;
      if (pv && !hs && (bus.oOUT_VALID !== 1'b1 || bus.oOUT_DATA !== pd || bus.oOUT_LAST !== pl))
        stallbad++;
      if (pv && bus.oOUT_VALID && bus.oFHT_ADDR_RD !== pa) addrbad++;
      if (bus.oFHT_ADDR_RD !== pa) begin
        alog = {alog[5:0], bus.oFHT_ADDR_RD};
        naddr++;
      end
      if (bus.oFHT_WE !== 4'b0) webad++;
    end
    bus.iOUT_READY = 1'b0;
    bus.iADC_VALID = 1'b0;
    chk("drain_count", got, nw);
    if (nw == 16) begin
      chk("rd_addr_seq", {naddr[3:0], alog}, {4'd4, 8'h27});
      chk("stall_stable", stallbad, 0);
      chk("addr_hold_out", addrbad, 0);
      chk("no_wr_outside_load", webad, 0);
      chk("frame_end", {bus.oADC_READY, bus.oBUSY}, 2'b10);
      if (!rnd) chk("drain_cycles", last_edge, 28);
    end
  endtask

  task automatic reset_pulse();
    #1;
    rst = 1'b1;
    bus.iADC_VALID = 1'b0;
    #1;
    chk("reset_async", outs(), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {bus.oADC_READY, bus.oBUSY}, 2'b10);
  endtask

  initial begin
    bus.iADC_VALID = 1'b0;
    bus.iADC_DATA  = '0;
    bus.iFHT_RDY   = 1'b0;
    bus.iOUT_READY = 1'b0;
    cur_seed       = '0;

    repeat (2) tick();
    chk("reset_state", outs(), 0);
    rst = 1'b0;
    tick();
    chk("ready_rise", {bus.oADC_READY, bus.oBUSY}, 2'b10);

    // Mapping, start pulse, completion edge, bit-reversed readout.
    bus.iFHT_RDY = 1'b1;
    cur_seed = 16'h0000;
    load_frame(1'b0, 16);
    after_load();
    wait_phase(1'b0);
    drain(1'b0, 16);

    // Gapped input, ADC valid held high outside LOAD, random backpressure.
    cur_seed = 16'h8003;
    load_frame(1'b1, 16);
    after_load();
    wait_phase(1'b1);
    drain(1'b1, 16);

    // Reset during sample 7 of LOAD, then a fresh frame.
    cur_seed = 16'h0100;
    load_frame(1'b0, 7);
    bus.iADC_VALID = 1'b1;
    bus.iADC_DATA  = cur_seed + 16'd7;
    reset_pulse();
    cur_seed = 16'h1234;
    load_frame(1'b0, 16);
    after_load();
    wait_phase(1'b0);
    drain(1'b0, 16);

    // Reset during OUT, then a fresh frame under backpressure.
    cur_seed = 16'hfff0;
    load_frame(1'b0, 16);
    after_load();
    wait_phase(1'b0);
    drain(1'b0, 6);
    reset_pulse();
    cur_seed = 16'h7ff8;
    load_frame(1'b0, 16);
    after_load();
    wait_phase(1'b0);
    drain(1'b1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fht_frame_ctrl.md
# fht_frame_ctrl

Frame sequencer placed in front of `fht_top`.
- Loads one frame of ADC samples into the four FHT RAM banks through the write port.
- Pulses start, waits for the transform to finish, then reads the result back through the read ports.
- Reorders the result from bit-reversed to natural order and streams it out with valid/ready.
- Replaces the hand-driven load/start/readback sequence used in simulation with synthesizable control.

## Interface

Parameters:
- `ADC_WIDTH`, 16: ADC sample width.
- `D_BIT`, 22: FHT data width; must be greater than `ADC_WIDTH`.
- `A_BIT`, 8: bank address width. Bank depth is 2^A_BIT; frame length N = 4·2^A_BIT.
- `RD_LAT`, 2: FHT RAM read latency in cycles (1..3).

Ports:
- `iCLK` in 1: single clock; all logic on the rising edge.
- `iRESET` in 1: asynchronous, active-high reset.
- `iADC_VALID` in 1: sample valid.
- `iADC_DATA` in ADC_WIDTH: signed sample.
- `oADC_READY` out 1: block accepts a sample.
- `oFHT_WE` out 4: one-hot bank write enable, to `fht_top.iWE`.
- `oFHT_DATA` out D_BIT: write data, to `iDATA`.
- `oFHT_ADDR_WR` out A_BIT: write address, to `iADDR_WR`.
- `oFHT_START` out 1: one-cycle start pulse, to `iSTART`.
- `iFHT_RDY` in 1: from `fht_top.oRDY`.
- `oFHT_ADDR_RD` out A_BIT: read address, fanned to `iADDR_RD_0..3`.
- `iFHT_DATA_0`..`iFHT_DATA_3` in D_BIT each: bank read data.
- `oOUT_VALID` out 1: result word valid.
- `oOUT_DATA` out D_BIT: result word.
- `oOUT_LAST` out 1: marks word N-1 of the frame.
- `iOUT_READY` in 1: downstream accepts the word.
- `oBUSY` out 1: high in any state other than LOAD.

## Operation

State machine: LOAD → START → WAIT → RADDR → RWAIT → OUT → (RADDR | LOAD).

- **LOAD**
  - `oADC_READY`=1. Sample index k counts 0..N-1 and is incremented on each valid&ready.
  - Sample k is written to bank k mod 4 at row k/4 (row-major, four banks per row).
  - Write data is `{iADC_DATA, (D_BIT-ADC_WIDTH) zeros}`, i.e. the integer sample placed in the top bits of the fixed-point word.
  - After accepting k = N-1, go to START; k wraps to 0.
- **START**
  - `oFHT_START`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - Register `iFHT_RDY` every cycle.
  - Leave on the first rising edge of `iFHT_RDY` (current=1, previous=0) detected after START.
  - A level that is already high does not count as completion.
  - Then set row r=0 and go to RADDR.
- **RADDR**
  - `oFHT_ADDR_RD` = bitrev_A_BIT(r), held constant until the row is captured.
  - Go to RWAIT.
- **RWAIT**
  - Count RD_LAT cycles after the address was applied.
  - On the last count, capture `iFHT_DATA_0..3` into a 4-word holding register.
  - Then go to OUT with bank index b=0.
- **OUT**
  - `oOUT_DATA` = hold[b]; `oOUT_VALID`=1.
  - On valid&ready: increment b.
  - After b=3 is accepted: if r = 2^A_BIT-1, go to LOAD; otherwise r+1 and go to RADDR.
  - `oOUT_LAST`=1 only while r = 2^A_BIT-1 and b=3.

Output word order is therefore row bitrev(0) banks 0..3, then row bitrev(1) banks 0..3, and so on.

## Timing

Reset (`iRESET`=1, asynchronous):
- State goes to LOAD; k, r and b are cleared.
- All outputs are 0: `oADC_READY`, `oFHT_WE`, `oFHT_DATA`, `oFHT_ADDR_WR`, `oFHT_START`, `oFHT_ADDR_RD`, `oOUT_VALID`, `oOUT_DATA`, `oOUT_LAST`, `oBUSY`.
- `oADC_READY` rises on the first `iCLK` edge after reset release.
- Reset asserted mid-frame (any state) discards the frame. The FHT RAM contents are not cleared.

Write path:
- `oFHT_WE`, `oFHT_DATA` and `oFHT_ADDR_WR` are registered.
- A sample accepted at edge t produces a WE pulse of exactly one cycle, starting at edge t.
- Back-to-back acceptance gives one write per cycle; a gap in `iADC_VALID` gives `oFHT_WE`=0 for that cycle.
- `oADC_READY` is 0 from the edge that accepts sample N-1.
- `oFHT_START` is high in the cycle immediately after the last WE pulse.

Read path:
- Per row: 1 cycle (RADDR) + RD_LAT cycles (RWAIT) + at least 4 cycles (OUT).
- With `iOUT_READY` held at 1, a frame drains in 2^A_BIT·(5+RD_LAT) cycles.
- `oOUT_VALID`/`oOUT_DATA` stay stable while `iOUT_READY`=0.
- `iFHT_DATA` is never sampled outside RWAIT.

Boundaries:
- `iADC_VALID` outside LOAD is ignored, with no write.
- `iOUT_READY` outside OUT is ignored.
- `iFHT_RDY` glitches outside WAIT are ignored, but its registered copy still updates every cycle.
- The next frame's first sample is accepted at the earliest one cycle after the last output handshake.

## Test plan

1. **Load mapping.** A_BIT=2, N=16, samples 0..15 back-to-back.
   - Expect WE pulses 0001,0010,0100,1000 repeating, addr 0,0,0,0,1,…,3.
   - Data for sample 5 = 5<<(D_BIT-ADC_WIDTH).
   - Expect `oFHT_START` exactly 1 cycle after the 16th WE.
2. **Completion detect.** Hold `iFHT_RDY`=1 through START, drop it 3 cycles later, raise it 20 cycles later.
   - Expect no read before the rise.
   - Expect `oFHT_ADDR_RD`=0 on the cycle after the rise.
3. **Bit-reversed readout.** A_BIT=2 with a behavioural RAM model, RD_LAT=2, row content = row·4+bank.
   - Expect read addresses 0,2,1,3.
   - Expect output 0,1,2,3,8,9,10,11,4,5,6,7,12,13,14,15, with `oOUT_LAST` only on the 16th word.
4. **Backpressure.** Random `iOUT_READY` (50%).
   - Expect the same 16-word sequence and stable data while stalled.
   - Expect no `oFHT_ADDR_RD` change during OUT.
5. **Gapped input and ignored inputs.** Hold `iADC_VALID` low on alternate cycles.
   - Expect exactly 16 writes with no WE on gap cycles.
   - `iADC_VALID` held high during WAIT/OUT produces no writes and no change to k.
6. **Reset mid-operation.** Assert `iRESET` during sample 7 of LOAD, and separately during OUT.
   - Expect all outputs 0 immediately (asynchronous).
   - A fresh frame of 16 samples then completes correctly.
